fir_axis_sink: RTL and testbench
================================

Name: fir_axis_sink

Overview:
- AXI-Stream consumer for the 32-bit FIR output stream.
- Converts each accepted 32-bit result to signed 16-bit: round-half-up, shift right, saturate.
- Buffers converted samples in a small FIFO and re-emits them on a 16-bit AXI-Stream master.
- Tracks per-window peak magnitude and a saturation count; sits directly downstream of FIR in the datapath and in benches.

Parameters:
- IN_W, 32, input sample width (signed).
- OUT_W, 16, output sample width (signed).
- FRAC_SHIFT, 15, right-shift applied before saturation; must be >= 1.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- STALL_PERIOD, 8, backpressure period in cycles; used only with FIR_SINK_STALL_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable.
- s_axis_fir_tdata  in  IN_W  signed FIR result.
- s_axis_fir_tvalid  in  1  input beat valid.
- s_axis_fir_tready  out  1  input beat accepted when high with tvalid.
- m_axis_out_tdata  out  OUT_W  converted signed sample.
- m_axis_out_tvalid  out  1  output valid.
- m_axis_out_tready  in  1  downstream ready.
- win_len  in  16  peak window length in accepted samples; 0 disables peak reporting.
- peak_abs  out  OUT_W  max |sample| of the last completed window, unsigned; 32768 representable.
- peak_valid  out  1  one-cycle pulse when peak_abs updates.
- sat_cnt  out  16  saturation events; sticks at 0xFFFF.
- busy  out  1  high in RUN or FLUSH.

Behaviour:
- Reset (async, active-high): all outputs 0; FIFO emptied; state IDLE; peak tracker and window counter cleared.
- States:
  - IDLE: s_axis_fir_tready=0. Go to RUN when en=1.
  - RUN: s_axis_fir_tready = (fifo_count < DEPTH). Go to FLUSH when en=0.
  - FLUSH: s_axis_fir_tready=0. Drain the FIFO to the output. Go to IDLE when the FIFO is empty and no beat is pending. If en=1 in FLUSH, return to RUN.
- Ready is a function of registered count only. No combinational path from m_axis_out_tready to s_axis_fir_tready. When the FIFO is full, an input beat is not accepted even if a pop occurs in the same cycle.
- Conversion:
  - t = sext(in, IN_W+1) + 2^(FRAC_SHIFT-1); q = t >>> FRAC_SHIFT.
  - If q > 2^(OUT_W-1)-1, output 0x7FFF and increment sat_cnt.
  - If q < -2^(OUT_W-1), output 0x8000 and increment sat_cnt.
  - Otherwise output q[OUT_W-1:0].
- Latency: a beat accepted at edge N appears on m_axis_out_tdata with tvalid=1 after edge N+1 when the FIFO was empty.
- Output data holds stable while tvalid=1 and tready=0.
- Order is preserved. Simultaneous push and pop with count unchanged is legal when not full.
- Peak tracking:
  - Each accepted beat updates run_max with |out|, where |0x8000| = 32768.
  - The window counter increments per accepted beat.
  - When the counter reaches win_len: peak_abs <= max including the current beat; peak_valid=1 for one cycle; counter and run_max clear.
  - A change to win_len mid-window takes effect when the current window closes. If win_len is lowered below the current count, the window closes on the next accepted beat.
- sat_cnt is never cleared except by reset.
- Reset mid-transfer discards FIFO contents; no partial beats are emitted.

Optional Feature:
- Macro FIR_SINK_STALL_EN.
- When defined: a free-running counter modulo STALL_PERIOD forces s_axis_fir_tready=0 for one cycle in every STALL_PERIOD (at counter==STALL_PERIOD-1), in RUN only. Used to exercise upstream backpressure.
- When undefined: no counter is present; ready follows the RUN rule above exactly.

Decomposition:
- Package fir_sink_pkg holds:
  - state enum {IDLE, RUN, FLUSH};
  - OUT_MAX and OUT_MIN constants;
  - a saturating-round function shared with future sinks.
- One sub-module, fir_sink_fifo: synchronous FIFO, DEPTH x OUT_W, registered first-word-fall-through output, count output.

Test Plan:
- en=1, input 0x3FFF8000 → output 0x7FFF after 1 cycle, sat_cnt=0; input 0x00004000 → 0x0001; input 0xFFFFC000 → 0x0000.
- Input 0x40000000 → 0x7FFF, sat_cnt=1; input 0xC0000000 → 0x8000, no increment; input 0xBFFF0000 → 0x8000, sat_cnt=2.
- m_axis_out_tready=0 with continuous tvalid → exactly 4 beats accepted, then s_axis_fir_tready=0. Release → 4 outputs in order, then input accepted again.
- win_len=8, repeating sinusoid 0, 0x2D3F0000, 0x3FFF8000, 0x2D3F0000, 0, negatives → peak_valid pulses every 8 accepted beats with peak_abs=0x7FFF.
- Drop en with 3 entries queued → busy holds through FLUSH, all 3 emitted, then IDLE with tready=0. Assert reset mid-stream → all outputs 0 immediately.
- With FIR_SINK_STALL_EN and STALL_PERIOD=8 in RUN with the FIFO drained → s_axis_fir_tready low exactly 1 of every 8 cycles; data order intact.

Source files
------------

// File: rtl/fir_sink_pkg.sv
// fir_sink_pkg: shared state type, output limits and the round/saturate
// helper used by FIR stream sinks.
package fir_sink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int SINK_OUT_W = 16;

    localparam logic signed [SINK_OUT_W-1:0] OUT_MAX = 16'sh7FFF;
    localparam logic signed [SINK_OUT_W-1:0] OUT_MIN = 16'sh8000;

    typedef struct packed {
        logic [SINK_OUT_W-1:0] val;
        logic                  sat;
    } sat_t;

    // Round half up, arithmetic shift, then clamp into the output range.
    function automatic sat_t sat_round(
        input logic signed [63:0] x,
        input int                 shift
    );
        logic signed [63:0] t;
        logic signed [63:0] q;
        sat_t               r;
        t     = x + (64'sd1 <<< (shift - 1));
        q     = t >>> shift;
        r.sat = 1'b0;
        r.val = q[SINK_OUT_W-1:0];
        if (q > 64'(OUT_MAX)) begin
            r.val = OUT_MAX;
            r.sat = 1'b1;
        end else if (q < 64'(OUT_MIN)) begin
            r.val = OUT_MIN;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sink_fifo.sv
// fir_sink_fifo: DEPTH x W synchronous FIFO with a registered
// first-word-fall-through head and an occupancy count.
module fir_sink_fifo
    import fir_sink_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dout_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d, rd_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          push_ok, pop_ok;

    // The head register only sees entries already in memory, so a write
    // becomes visible one edge after it lands.
    always_comb begin
        push_ok = push_i && (cnt_q != CW'(DEPTH));
        pop_ok  = pop_i && vld_q;
        rd_nxt  = rd_q + AW'(1);
        wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d    = pop_ok ? rd_nxt : rd_q;
        cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
        vld_d   = vld_q;
        dout_d  = dout_q;
        if (pop_ok) begin
            vld_d = (cnt_q > CW'(1));
            if (cnt_q > CW'(1)) begin
                dout_d = mem_q[rd_nxt];
            end
        end else if (!vld_q && (cnt_q != '0)) begin
            vld_d  = 1'b1;
            dout_d = mem_q[rd_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = vld_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/fir_axis_sink.sv
// fir_axis_sink: FIR result sink; round/saturate to 16 bits, FIFO re-emit,
// windowed peak and saturation count. FIR_SINK_STALL_EN adds periodic stalls.
module fir_axis_sink
    import fir_sink_pkg::*;
#(
    parameter int IN_W         = 32,
    parameter int OUT_W        = SINK_OUT_W,
    parameter int FRAC_SHIFT   = 15,
    parameter int DEPTH        = 4,
    parameter int STALL_PERIOD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IN_W-1:0]  s_axis_fir_tdata,
    input  logic             s_axis_fir_tvalid,
    output logic             s_axis_fir_tready,
    output logic [OUT_W-1:0] m_axis_out_tdata,
    output logic             m_axis_out_tvalid,
    input  logic             m_axis_out_tready,
    input  logic [15:0]      win_len,
    output logic [OUT_W-1:0] peak_abs,
    output logic             peak_valid,
    output logic [15:0]      sat_cnt,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    fifo_cnt;
    logic             stall;
    logic             accept;
    sat_t             sr;
    logic [OUT_W-1:0] conv;
    logic [OUT_W-1:0] mag;

    logic [15:0]      win_cnt_q, win_cnt_d;
    logic [15:0]      win_q, win_d;
    logic [15:0]      lim;
    logic [16:0]      cnt_inc;
    logic             close;
    logic [OUT_W-1:0] run_max_q, run_max_d;
    logic [OUT_W-1:0] max_cur;
    logic [OUT_W-1:0] peak_q, peak_d;
    logic             pv_q, pv_d;
    logic [15:0]      sat_q, sat_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = FLUSH;
            FLUSH: begin
                if (en) begin
                    state_d = RUN;
                end else if (fifo_cnt == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready depends on registered state and count only.
    assign s_axis_fir_tready = (state_q == RUN)
                            && (fifo_cnt < CW'(DEPTH))
                            && !stall;
    assign accept = s_axis_fir_tvalid && s_axis_fir_tready;
    assign busy   = (state_q != IDLE);

    always_comb begin
        sr   = sat_round(64'($signed(s_axis_fir_tdata)), FRAC_SHIFT);
        conv = OUT_W'(sr.val);
        mag  = conv[OUT_W-1] ? (~conv + OUT_W'(1)) : conv;
    end

    fir_sink_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .din_i   (conv),
        .pop_i   (m_axis_out_tready),
        .dout_o  (m_axis_out_tdata),
        .valid_o (m_axis_out_tvalid),
        .count_o (fifo_cnt)
    );

    // Window length is sampled while the window is empty and then held,
    // except that a length already passed by the count closes it early.
    always_comb begin
        lim       = (win_cnt_q == '0) ? win_len : win_q;
        cnt_inc   = {1'b0, win_cnt_q} + 17'd1;
        max_cur   = (mag > run_max_q) ? mag : run_max_q;
        close     = (cnt_inc >= {1'b0, lim})
                 || ((win_len != '0) && (win_cnt_q >= win_len));
        win_cnt_d = win_cnt_q;
        win_d     = lim;
        run_max_d = run_max_q;
        peak_d    = peak_q;
        pv_d      = 1'b0;
        if (accept && (lim != '0)) begin
            if (close) begin
                peak_d    = max_cur;
                pv_d      = 1'b1;
                win_cnt_d = '0;
                run_max_d = '0;
                win_d     = win_len;
            end else begin
                win_cnt_d = cnt_inc[15:0];
                run_max_d = max_cur;
            end
        end
        sat_d = sat_q;
        if (accept && sr.sat && (sat_q != 16'hFFFF)) begin
            sat_d = sat_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_q <= '0;
            win_q     <= '0;
            run_max_q <= '0;
            peak_q    <= '0;
            pv_q      <= 1'b0;
            sat_q     <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_q     <= win_d;
            run_max_q <= run_max_d;
            peak_q    <= peak_d;
            pv_q      <= pv_d;
            sat_q     <= sat_d;
        end
    end

    assign peak_abs   = peak_q;
    assign peak_valid = pv_q;
    assign sat_cnt    = sat_q;

`ifdef FIR_SINK_STALL_EN
    localparam int SW = $clog2(STALL_PERIOD + 1);

    logic [SW-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = (stall_q == SW'(STALL_PERIOD - 1)) ? '0 : stall_q + SW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall = (state_q == RUN) && (stall_q == SW'(STALL_PERIOD - 1));
`else
    // No stall counter in this build; the expression is constant false.
    assign stall = (STALL_PERIOD < 0);
`endif

endmodule

// File: tb/tb_fir_axis_sink.sv
// tb_fir_axis_sink: directed vector table plus hand-written sequences for
// backpressure, peak windows, flush and asynchronous reset.
module tb_fir_axis_sink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] win_len = '0;
    logic [15:0] peak_abs;
    logic        peak_valid;
    logic [15:0] sat_cnt;
    logic        busy;

    always #5 clk = ~clk;

    fir_axis_sink dut (
        .clk               (clk),
        .reset             (reset),
        .en                (en),
        .s_axis_fir_tdata  (s_tdata),
        .s_axis_fir_tvalid (s_tvalid),
        .s_axis_fir_tready (s_tready),
        .m_axis_out_tdata  (m_tdata),
        .m_axis_out_tvalid (m_tvalid),
        .m_axis_out_tready (m_tready),
        .win_len           (win_len),
        .peak_abs          (peak_abs),
        .peak_valid        (peak_valid),
        .sat_cnt           (sat_cnt),
        .busy              (busy)
    );

    int errors = 0;
    int checks = 0;

    int          acc_n = 0;
    int          pk_n = 0;
    logic [15:0] out_q[$];
    logic [15:0] pk_q[$];

    always @(negedge clk) begin
        if (s_tvalid && s_tready) acc_n++;
        if (m_tvalid && m_tready) out_q.push_back(m_tdata);
        if (peak_valid) begin
            pk_n++;
            pk_q.push_back(peak_abs);
        end
    end

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic [15:0] sat;
    } vec_t;

    vec_t        vecs[15];
    logic [31:0] sin8[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        if (!ok) tmo("send");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mvalid"}, m_tvalid, 0);
        chk({tag, "_mdata"}, m_tdata, 0);
        chk({tag, "_sready"}, s_tready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sat"}, sat_cnt, 0);
        chk({tag, "_peak"}, peak_abs, 0);
        chk({tag, "_pvalid"}, peak_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ob;
        int ab;
        int pb;
        int pnb;
        vecs[0]  = '{32'h3FFF8000, 16'h7FFF, 16'd0};
        vecs[1]  = '{32'h00004000, 16'h0001, 16'd0};
        vecs[2]  = '{32'hFFFFC000, 16'h0000, 16'd0};
        vecs[3]  = '{32'h40000000, 16'h7FFF, 16'd1};
        vecs[4]  = '{32'hC0000000, 16'h8000, 16'd1};
        vecs[5]  = '{32'hBFFF0000, 16'h8000, 16'd2};
        vecs[6]  = '{32'h00003FFF, 16'h0000, 16'd2};
        vecs[7]  = '{32'hFFFFBFFF, 16'hFFFF, 16'd2};
        vecs[8]  = '{32'h00018000, 16'h0003, 16'd2};
        vecs[9]  = '{32'h3FFFC000, 16'h7FFF, 16'd3};
        vecs[10] = '{32'h80000000, 16'h8000, 16'd4};
        vecs[11] = '{32'h7FFFFFFF, 16'h7FFF, 16'd5};
        vecs[12] = '{32'hC0004000, 16'h8001, 16'd5};
        vecs[13] = '{32'hBFFFC000, 16'h8000, 16'd5};
        vecs[14] = '{32'hBFFFBFFF, 16'h8000, 16'd6};
        sin8 = '{32'h00000000, 32'h2D3F0000, 32'h3FFF8000, 32'h2D3F0000,
                 32'h00000000, 32'hD2C10000, 32'hC0008000, 32'hD2C10000};

        // Reset state
        #3;
        chk_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("idle_ready", s_tready, 0);
        en = 1'b1;
        tick();
        chk("run_busy", busy, 1);

        // Conversion table
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].din);
            chk($sformatf("lat%0d", i), m_tvalid, 0);
            tick();
            chk($sformatf("vld%0d", i), m_tvalid, 1);
            chk($sformatf("data%0d", i), m_tdata, vecs[i].dout);
            chk($sformatf("sat%0d", i), sat_cnt, vecs[i].sat);
            tick();
        end

        // Backpressure: full FIFO stops input, release drains in order
        m_tready = 1'b0;
        ob = out_q.size();
        ab = acc_n;
        s_tvalid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_tdata = 32'(acc_n - ab + 1) << 15;
            tick();
        end
        chk("bp_acc", acc_n - ab, 4);
        chk("bp_ready", s_tready, 0);
        chk("bp_hold_v", m_tvalid, 1);
        chk("bp_hold_d", m_tdata, 1);
        m_tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (acc_n - ab >= 6) break;
            s_tdata = 32'(acc_n - ab + 1) << 15;
            tick();
        end
        s_tvalid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_q.size() - ob >= 6) break;
            tick();
        end
        chk("bp_reaccept", acc_n - ab, 6);
        if (out_q.size() - ob < 6) tmo("bp_drain");
        for (int k = 0; k < 6; k++) begin
            if (ob + k < out_q.size())
                chk($sformatf("bp_order%0d", k), out_q[ob + k], k + 1);
        end

        // Peak windows of 8 on a sinusoid
        win_len = 16'd8;
        pb = pk_q.size();
        pnb = pk_n;
        for (int i = 0; i < 7; i++) send(sin8[i]);
        repeat (3) tick();
        chk("win_early", pk_n - pnb, 0);
        send(sin8[7]);
        repeat (3) tick();
        chk("win_first", pk_n - pnb, 1);
        if (pk_q.size() > pb) chk("win_peak0", pk_q[pb], 16'h7FFF);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) send(sin8[i]);
        repeat (3) tick();
        chk("win_three", pk_n - pnb, 3);
        if (pk_q.size() > pb + 2) begin
            chk("win_peak1", pk_q[pb + 1], 16'h7FFF);
            chk("win_peak2", pk_q[pb + 2], 16'h7FFF);
        end

        // Windows of 4: small peak, then |0x8000|, then early close
        win_len = 16'd4;
        pb = pk_q.size();
        pnb = pk_n;
        send(32'h00008000);
        send(32'hFFFE8000);
        send(32'h00010000);
        send(32'h00000000);
        send(32'hC0000000);
        send(32'h00000000);
        send(32'h00000000);
        send(32'h00000000);
        win_len = 16'd8;
        send(32'h00020000);
        repeat (4) send(32'h00000000);
        win_len = 16'd2;
        send(32'h00008000);
        repeat (3) tick();
        chk("w4_count", pk_n - pnb, 3);
        if (pk_q.size() > pb + 2) begin
            chk("w4_peak3", pk_q[pb], 16'h0003);
            chk("w4_peak8000", pk_q[pb + 1], 16'h8000);
            chk("w_lowered", pk_q[pb + 2], 16'h0004);
        end
        win_len = 16'd0;

        // Flush with three queued entries
        m_tready = 1'b0;
        ob = out_q.size();
        send(32'h00038000);
        send(32'h00040000);
        send(32'h00048000);
        en = 1'b0;
        tick();
        chk("fl_busy0", busy, 1);
        chk("fl_ready", s_tready, 0);
        repeat (3) tick();
        chk("fl_busy1", busy, 1);
        chk("fl_head", m_tvalid, 1);
        m_tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            tick();
        end
        if (busy) tmo("fl_idle");
        chk("fl_count", out_q.size() - ob, 3);
        for (int k = 0; k < 3; k++) begin
            if (ob + k < out_q.size())
                chk($sformatf("fl_order%0d", k), out_q[ob + k], k + 7);
        end
        ab = acc_n;
        s_tvalid = 1'b1;
        s_tdata = 32'h00008000;
        repeat (3) tick();
        s_tvalid = 1'b0;
        chk("idle_noacc", acc_n - ab, 0);
        chk("idle_tready", s_tready, 0);

        // Asynchronous reset mid-stream
        en = 1'b1;
        m_tready = 1'b0;
        send(32'h40000000);
        send(32'h00010000);
        tick();
        chk("pre_rst_sat", sat_cnt, 7);
        chk("pre_rst_vld", m_tvalid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("arst");
        ob = out_q.size();
        @(negedge clk);
        reset = 1'b0;
        m_tready = 1'b1;
        repeat (6) tick();
        chk("arst_noemit", out_q.size() - ob, 0);
        chk("arst_vld", m_tvalid, 0);

`ifdef FIR_SINK_STALL_EN
        begin
            int lows;
            lows = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (!s_tready) lows++;
            end
            chk("stall_lows", lows, 2);
            ob = out_q.size();
            for (int k = 1; k <= 8; k++) send(32'(k) << 15);
            repeat (6) tick();
            chk("stall_count", out_q.size() - ob, 8);
            for (int k = 0; k < 8; k++) begin
                if (ob + k < out_q.size())
                    chk($sformatf("stall_order%0d", k), out_q[ob + k], k + 1);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
